// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank and its per-pin filter.
package gpio_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 16;
    localparam int unsigned DEFAULT_DEB_CNT_W = 4;

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input path: 2-flop synchroniser, debounce counter and sticky edge interrupt flag.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int unsigned DEB_CNT_W = DEFAULT_DEB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic [DEB_CNT_W-1:0] deb_len,
    input  logic                 ts,
    input  logic                 rise_en,
    input  logic                 fall_en,
    input  logic                 clr,
    output logic                 state,
    output logic                 pending
);

    logic [1:0]           sync_q;
    logic                 sync;
    logic [DEB_CNT_W-1:0] cnt;
    logic                 flip;
    logic                 set;

    assign sync = sync_q[1];
    assign flip = (sync != state) && (cnt >= deb_len);
    // Flag is raised on the same edge the debounced value changes.
    assign set  = flip && ts && ((sync && rise_en) || (!sync && fall_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt     <= '0;
            state   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            if (sync == state) begin
                cnt <= '0;
            end else if (flip) begin
                state <= sync;
                cnt   <= '0;
            end else if (cnt != {DEB_CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
            if (set) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: registered pad output path plus WIDTH debounced, interrupt-capable input filters.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEB_CNT_W = DEFAULT_DEB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gpio_ts,
    input  logic [WIDTH-1:0]     gpio_dr,
    input  logic [WIDTH-1:0]     gpio_input,
    input  logic [DEB_CNT_W-1:0] deb_len,
    input  logic [WIDTH-1:0]     irq_rise_en,
    input  logic [WIDTH-1:0]     irq_fall_en,
    input  logic [WIDTH-1:0]     irq_clr,
    output logic [WIDTH-1:0]     pad_oe,
    output logic [WIDTH-1:0]     pad_do,
    output logic [WIDTH-1:0]     pin_state,
    output logic [WIDTH-1:0]     irq_pending,
    output logic                 irq
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_oe <= '0;
            pad_do <= '0;
        end else begin
            pad_oe <= ~gpio_ts;
            pad_do <= gpio_dr;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_filter #(
            .DEB_CNT_W(DEB_CNT_W)
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .din     (gpio_input[i]),
            .deb_len (deb_len),
            .ts      (gpio_ts[i]),
            .rise_en (irq_rise_en[i]),
            .fall_en (irq_fall_en[i]),
            .clr     (irq_clr[i]),
            .state   (pin_state[i]),
            .pending (irq_pending[i])
        );
    end

    assign irq = |irq_pending;

endmodule
